// File: rtl/n0prime_top_level.sv
// RSA-CRT / Montgomery constant engine: from primes p, q computes qinv = q^-1 mod p
// and t = -(p*q)^-1 mod 2^W with an iterative multi-cycle FSM and start/done handshake.
`timescale 1ns/1ps

module n0prime_top_level #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] p,
   input  logic [W-1:0] q,
   output logic [W-1:0] qinv,
   output logic [W-1:0] t,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int CW = $clog2(2*W + 3);
   localparam int IW = $clog2(W);
   localparam logic [CW-1:0] RED_LAST = CW'(W - 1);
   localparam logic [CW-1:0] N0P_LAST = CW'(W - 1);
   localparam logic [CW-1:0] INV_MAX  = CW'(2*W + 2);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_RED, S_INV, S_N0P, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    p_q, p_d, q_q, q_d, n_q, n_d, rem_q, rem_d;
   logic [W-1:0]    u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
   logic [W-1:0]    inv_res_q, inv_res_d, y_q, y_d;
   logic [W-1:0]    qinv_q, qinv_d, t_q, t_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            inv_fail_q, inv_fail_d, err_q, err_d;

   logic [W:0]      rem_sh;
   logic [W-1:0]    rem_nx, ny, bit_i, y_nx;

   // (a - b) mod m for a, b already in [0, m-1]; wraparound of a-b+m lands back in range.
   function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, b, m);
      return (a >= b) ? a - b : a - b + m;
   endfunction

   function automatic logic [W-1:0] half_mod(input logic [W-1:0] a, m);
      logic [W:0] s;
      s = a[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a};
      return W'(s >> 1);
   endfunction

   always_comb begin
      // NOTE: every next-state signal takes its current value first, so no path infers a latch.
      state_d    = state_q;
      p_d        = p_q;
      q_d        = q_q;
      n_d        = n_q;
      rem_d      = rem_q;
      u_d        = u_q;
      v_d        = v_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      inv_res_d  = inv_res_q;
      inv_fail_d = inv_fail_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      qinv_d     = qinv_q;
      t_d        = t_q;
      err_d      = err_q;

      rem_sh = {rem_q, q_q[W-1]};
      rem_nx = (rem_sh >= {1'b0, p_q}) ? W'(rem_sh - {1'b0, p_q}) : rem_sh[W-1:0];
      ny     = n_q * y_q;
      bit_i  = '0;
      bit_i[cnt_q[IW-1:0]] = 1'b1;
      y_nx   = ny[cnt_q[IW-1:0]] ? (y_q | bit_i) : y_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               p_d        = p;
               q_d        = q;
               inv_fail_d = 1'b0;
               inv_res_d  = '0;
               state_d    = S_MUL;
            end
         end
         S_MUL: begin
            n_d   = p_q * q_q;
            rem_d = '0;
            cnt_d = '0;
            // Inversion mod p needs an odd p >= 3; otherwise only t is computed.
            if (p_q < W'(2) || !p_q[0]) begin
               inv_fail_d = 1'b1;
               y_d        = W'(1);
               cnt_d      = CW'(1);
               state_d    = S_N0P;
            end else begin
               state_d = S_RED;
            end
         end
         S_RED: begin
            rem_d = rem_nx;
            q_d   = q_q << 1;
            if (cnt_q == RED_LAST) begin
               u_d     = p_q;
               v_d     = rem_nx;
               x1_d    = '0;
               x2_d    = W'(1);
               cnt_d   = '0;
               state_d = S_INV;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_INV: begin
            // Invariants: x1*r == u and x2*r == v (mod p); odd-odd steps subtract and halve at once.
            cnt_d = cnt_q + CW'(1);
            if (u_q == W'(1) || v_q == W'(1) || u_q == '0 || v_q == '0 || cnt_q == INV_MAX) begin
               inv_res_d  = (u_q == W'(1)) ? x1_q : x2_q;
               inv_fail_d = (u_q != W'(1)) && (v_q != W'(1));
               y_d        = W'(1);
               cnt_d      = CW'(1);
               state_d    = S_N0P;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = half_mod(x1_q, p_q);
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = half_mod(x2_q, p_q);
            end else if (u_q >= v_q) begin
               u_d  = (u_q - v_q) >> 1;
               x1_d = half_mod(sub_mod(x1_q, x2_q, p_q), p_q);
            end else begin
               v_d  = (v_q - u_q) >> 1;
               x2_d = half_mod(sub_mod(x2_q, x1_q, p_q), p_q);
            end
         end
         S_N0P: begin
            if (!n_q[0] || cnt_q == N0P_LAST) begin
               qinv_d  = inv_fail_q ? '0 : inv_res_q;
               t_d     = n_q[0] ? (~y_nx + W'(1)) : '0;
               err_d   = inv_fail_q | ~n_q[0];
               state_d = S_FIN;
            end else begin
               y_d   = y_nx;
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         p_q        <= '0;
         q_q        <= '0;
         n_q        <= '0;
         rem_q      <= '0;
         u_q        <= '0;
         v_q        <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         inv_res_q  <= '0;
         inv_fail_q <= 1'b0;
         y_q        <= '0;
         cnt_q      <= '0;
         qinv_q     <= '0;
         t_q        <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         q_q        <= q_d;
         n_q        <= n_d;
         rem_q      <= rem_d;
         u_q        <= u_d;
         v_q        <= v_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         inv_res_q  <= inv_res_d;
         inv_fail_q <= inv_fail_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         qinv_q     <= qinv_d;
         t_q        <= t_d;
         err_q      <= err_d;
      end
   end

   // FIN counts as not-busy for the handshake, yet start there is still ignored by the FSM.
   assign busy = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done = (state_q == S_FIN);
   assign qinv = qinv_q;
   assign t    = t_q;
   assign err  = err_q;

endmodule

// File: tb/tb_n0prime_top_level.sv
// Scoreboard bench for n0prime_top_level: reference model uses Euclid and Newton iteration,
// a negedge monitor pops expectations on every done pulse.
`timescale 1ns/1ps

module tb_n0prime_top_level;

   localparam int W       = 32;
   localparam int LAT_MAX = 5*W + 8;

   typedef struct {
      logic [W-1:0] p;
      logic [W-1:0] q;
      logic [W-1:0] qinv;
      logic [W-1:0] t;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] p, q, qinv, t;
   logic         busy, done, err;

   int   checks = 0;
   int   errors = 0;
   int   n_exp  = 0;
   int   n_done = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   n0prime_top_level #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .p    (p),
      .q    (q),
      .qinv (qinv),
      .t    (t),
      .busy (busy),
      .done (done),
      .err  (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Classic extended Euclid on signed 64-bit integers.
   function automatic logic [W-1:0] model_inv(input logic [W-1:0] a, input logic [W-1:0] m,
                                              output bit ok);
      longint r0, r1, s0, s1, qt, tmp;
      ok = 1'b0;
      if (m < 2 || m[0] == 1'b0) return '0;
      r0 = longint'(m);
      r1 = longint'(a % m);
      s0 = 0;
      s1 = 1;
      while (r1 != 0) begin
         qt  = r0 / r1;
         tmp = r0 - qt * r1;
         r0  = r1;
         r1  = tmp;
         tmp = s0 - qt * s1;
         s0  = s1;
         s1  = tmp;
      end
      if (r0 != 1) return '0;
      ok = 1'b1;
      if (s0 < 0) s0 += longint'(m);
      return W'(s0);
   endfunction

   function automatic exp_t model(input logic [W-1:0] pp, input logic [W-1:0] qq);
      exp_t         e;
      bit           ok;
      logic [W-1:0] n, x;
      e.p    = pp;
      e.q    = qq;
      n      = pp * qq;
      e.qinv = model_inv(qq, pp, ok);
      if (n[0]) begin
         x = n;  // correct to 3 bits for odd n; each Newton step doubles that
         for (int i = 0; i < 5; i++) x = x * (W'(2) - n * x);
         e.t = W'(0) - x;
      end else begin
         e.t = '0;
      end
      e.err = !ok || !n[0];
      return e;
   endfunction

   // Monitor: compares every done pulse against the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t         e;
      logic [W-1:0] nt;
      if (!rst && done) begin
         n_done++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with no outstanding start, qinv=0x%0h t=0x%0h", qinv, t);
         end else begin
            e = sb.pop_front();
            check($sformatf("qinv p=%0h q=%0h", e.p, e.q), 64'(qinv), 64'(e.qinv));
            check($sformatf("t p=%0h q=%0h", e.p, e.q), 64'(t), 64'(e.t));
            check($sformatf("err p=%0h q=%0h", e.p, e.q), 64'(err), 64'(e.err));
            if (!e.err) begin
               check("q_times_qinv_mod_p", (64'(e.q) * 64'(qinv)) % 64'(e.p), 64'd1);
               nt = e.p * e.q * t + W'(1);
               check("n_times_t_plus_1", 64'(nt), 64'd0);
            end
         end
      end
   end

   // Caller is one time step after a rising edge with the DUT idle.
   task automatic issue(input logic [W-1:0] pp, input logic [W-1:0] qq, input bit track);
      p     = pp;
      q     = qq;
      start = 1'b1;
      if (track) begin
         sb.push_back(model(pp, qq));
         n_exp++;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      p     = $urandom;
      q     = $urandom;
   endtask

   task automatic wait_done(input bit poke_start);
      bit seen = 1'b0;
      for (int c = 0; c <= LAT_MAX; c++) begin
         @(negedge clk);
         if (c == 0) check("busy_after_start", 64'(busy), 64'd1);
         if (done) begin
            seen = 1'b1;
            check("busy_low_at_done", 64'(busy), 64'd0);
            if (poke_start) begin
               start = 1'b1;
               p     = $urandom | 1;
               q     = $urandom | 1;
            end
            break;
         end
      end
      check("done_within_bound", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (poke_start) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("start_in_done_ignored", {62'd0, busy, done}, 64'd0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   logic [W-1:0] dir_p [10] = '{32'd3, 32'd11, 32'hFFFF_FFFF, 32'd10, 32'd7,
                                32'd7, 32'd13, 32'd5, 32'd5, 32'd1};
   logic [W-1:0] dir_q [10] = '{32'd1, 32'd3, 32'd1, 32'd3, 32'd14,
                                32'd2, 32'd0, 32'd12, 32'd13, 32'd1};

   initial begin
      int abort_dones;
      rst   = 1'b1;
      start = 1'b0;
      p     = '0;
      q     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_qinv", 64'(qinv), 64'd0);
      check("reset_t", 64'(t), 64'd0);
      check("reset_flags", {61'd0, busy, done, err}, 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         issue(dir_p[i], dir_q[i], 1'b1);
         wait_done(i == 1);
      end

      for (int i = 0; i < 16; i++) begin
         issue($urandom | 1, $urandom | 1, 1'b1);
         wait_done(1'b0);
      end

      // Abort a run partway through the inversion.
      issue(32'hFFFF_FFFB, 32'h1234_5679, 1'b0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("busy_mid_inv", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_qinv", 64'(qinv), 64'd0);
      check("abort_t", 64'(t), 64'd0);
      check("abort_flags", {61'd0, busy, done, err}, 64'd0);
      abort_dones = 0;
      for (int k = 0; k < LAT_MAX; k++) begin
         @(negedge clk);
         if (done) abort_dones++;
      end
      check("no_done_after_abort", 64'(abort_dones), 64'd0);
      @(posedge clk);
      #1;
      issue(32'd11, 32'd3, 1'b1);
      wait_done(1'b0);
      issue(32'hFFFF_FFFB, 32'h1234_5679, 1'b1);
      wait_done(1'b0);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      check("one_done_per_start", 64'(n_done), 64'(n_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
